// File: rtl/cwm_pkg.sv
// Shared sizing helpers for the cwait_merge_sync join and its channel FIFOs.
package cwm_pkg;

  // Count must represent 0..depth inclusive.
  function automatic int unsigned CWM_CNT_W(input int unsigned depth);
    return (depth < 1) ? 1 : $clog2(depth + 1);
  endfunction

  function automatic int unsigned CWM_PTR_W(input int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  // Low bit of channel k within a flat NUM_CH*dw bus.
  function automatic int unsigned cwm_lo(input int unsigned k, input int unsigned dw);
    return k * dw;
  endfunction

endpackage

// File: rtl/cwait_merge_sync_if.sv
// Upstream push/credit and downstream merged-token handshake bundle.
interface cwait_merge_sync_if #(
  parameter int unsigned NUM_CH     = 9,
  parameter int unsigned DATA_WIDTH = 3
);
  logic [NUM_CH-1:0]            i_drive;
  logic [NUM_CH*DATA_WIDTH-1:0] i_data;
  logic [NUM_CH-1:0]            o_free;
  logic [NUM_CH-1:0]            i_chEn;
  logic                         o_driveNext;
  logic [NUM_CH*DATA_WIDTH-1:0] o_data;
  logic                         i_freeNext;
  logic                         o_busy;
  logic [NUM_CH-1:0]            o_ovf;

  modport master (
    output i_drive, i_data, i_chEn, i_freeNext,
    input  o_free, o_driveNext, o_data, o_busy, o_ovf
  );

  modport slave (
    input  i_drive, i_data, i_chEn, i_freeNext,
    output o_free, o_driveNext, o_data, o_busy, o_ovf
  );
endinterface

// File: rtl/cwm_chan_fifo.sv
// DEPTH-entry circular FIFO for one join channel, with a sticky overflow flag.
module cwm_chan_fifo
  import cwm_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 3,
  parameter int unsigned DEPTH      = 2
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  i_push,
  input  logic                  i_pop,
  input  logic [DATA_WIDTH-1:0] i_data,
  output logic [DATA_WIDTH-1:0] o_head,
  output logic                  o_empty,
  output logic                  o_ovf
);
  localparam int unsigned CNT_W = CWM_CNT_W(DEPTH);
  localparam int unsigned PTR_W = CWM_PTR_W(DEPTH);
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
  localparam logic [PTR_W-1:0] LAST_C  = PTR_W'(DEPTH - 1);

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [CNT_W-1:0]      r_cnt;
  logic [PTR_W-1:0]      r_wr;
  logic [PTR_W-1:0]      r_rd;
  logic                  r_ovf;
  logic                  w_accept;

  // A same-cycle pop frees the slot the push is about to use.
  assign w_accept = i_push && ((r_cnt < DEPTH_C) || i_pop);
  assign o_head   = r_mem[r_rd];
  assign o_empty  = (r_cnt == '0);
  assign o_ovf    = r_ovf;

  always_ff @(posedge clk) begin
    if (w_accept) r_mem[r_wr] <= i_data;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_cnt <= '0;
      r_wr  <= '0;
      r_rd  <= '0;
      r_ovf <= 1'b0;
    end else begin
      if (w_accept) r_wr <= (r_wr == LAST_C) ? '0 : r_wr + 1'b1;
      if (i_pop)    r_rd <= (r_rd == LAST_C) ? '0 : r_rd + 1'b1;
      case ({w_accept, i_pop})
        2'b10:   r_cnt <= r_cnt + 1'b1;
        2'b01:   r_cnt <= r_cnt - 1'b1;
        default: r_cnt <= r_cnt;
      endcase
      if (i_push && !w_accept) r_ovf <= 1'b1;
    end
  end
endmodule

// File: rtl/cwait_merge_sync.sv
// Clocked N-input wait-merge: joins one token per enabled channel into a merged output slot.
module cwait_merge_sync
  import cwm_pkg::*;
#(
  parameter int unsigned NUM_CH     = 9,
  parameter int unsigned DATA_WIDTH = 3,
  parameter int unsigned DEPTH      = 2
) (
  input logic               clk,
  input logic               rstn,
  cwait_merge_sync_if.slave bus
);
  localparam int unsigned DW = DATA_WIDTH;

  logic [NUM_CH*DW-1:0] w_heads;
  logic [NUM_CH-1:0]    w_empty;
  logic [NUM_CH-1:0]    w_ovf;
  logic [NUM_CH-1:0]    w_pop;
  logic                 w_fire;
  logic [NUM_CH*DW-1:0] w_merged;

  logic                 r_full;
  logic [NUM_CH*DW-1:0] r_data;
  logic                 r_drive_next;
  logic [NUM_CH-1:0]    r_free;

  for (genvar gk = 0; gk < NUM_CH; gk++) begin : g_ch
    cwm_chan_fifo #(
      .DATA_WIDTH(DW),
      .DEPTH     (DEPTH)
    ) u_fifo (
      .clk    (clk),
      .rstn   (rstn),
      .i_push (bus.i_drive[gk]),
      .i_pop  (w_pop[gk]),
      .i_data (bus.i_data[cwm_lo(gk, DW) +: DW]),
      .o_head (w_heads[cwm_lo(gk, DW) +: DW]),
      .o_empty(w_empty[gk]),
      .o_ovf  (w_ovf[gk])
    );
  end

  // Disabled channels never block the join and contribute a zero slice.
  always_comb begin
    logic w_all_ready;
    w_all_ready = 1'b1;
    w_merged    = '0;
    for (int unsigned k = 0; k < NUM_CH; k++) begin
      if (bus.i_chEn[k]) begin
        if (w_empty[k]) w_all_ready = 1'b0;
        w_merged[k*DW +: DW] = w_heads[k*DW +: DW];
      end
    end
    w_fire = (|bus.i_chEn) && w_all_ready && (!r_full || bus.i_freeNext);
    w_pop  = w_fire ? bus.i_chEn : '0;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_full       <= 1'b0;
      r_data       <= '0;
      r_drive_next <= 1'b0;
      r_free       <= '0;
    end else begin
      r_drive_next <= w_fire;
      r_free       <= w_pop;
      if (w_fire) begin
        r_full <= 1'b1;
        r_data <= w_merged;
      end else if (bus.i_freeNext) begin
        r_full <= 1'b0;
      end
    end
  end

  assign bus.o_free      = r_free;
  assign bus.o_driveNext = r_drive_next;
  assign bus.o_data      = r_data;
  assign bus.o_busy      = r_full;
  assign bus.o_ovf       = w_ovf;
endmodule

// File: tb/tb_cwait_merge_sync.sv
// Randomised and directed checks of cwait_merge_sync against a queue-based join model.
module tb_cwait_merge_sync;
  localparam int unsigned NC = 3;
  localparam int unsigned DW = 4;
  localparam int unsigned D  = 2;

  logic clk;
  logic rstn;
  int   n_chk;
  int   n_fail;

  cwait_merge_sync_if #(.NUM_CH(NC), .DATA_WIDTH(DW)) bus ();

  cwait_merge_sync #(.NUM_CH(NC), .DATA_WIDTH(DW), .DEPTH(D)) dut (
    .clk (clk),
    .rstn(rstn),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: token queues per channel plus the output slot.
  logic [DW-1:0]    q [NC][$];
  logic             m_full;
  logic [NC*DW-1:0] m_data;
  logic             m_dn;
  logic [NC-1:0]    m_free;
  logic [NC-1:0]    m_ovf;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < NC; k++) q[k].delete();
    m_full = 1'b0;
    m_data = '0;
    m_dn   = 1'b0;
    m_free = '0;
    m_ovf  = '0;
  endtask

  task automatic check_all();
    check_eq("driveNext", bus.o_driveNext, m_dn);
    check_eq("free",      bus.o_free,      m_free);
    check_eq("data",      bus.o_data,      m_data);
    check_eq("busy",      bus.o_busy,      m_full);
    check_eq("ovf",       bus.o_ovf,       m_ovf);
  endtask

  // Applies one cycle of stimulus, advances the model, then compares after the edge.
  task automatic cycle(input logic [NC-1:0] drv, input logic [NC*DW-1:0] dat,
                       input logic [NC-1:0] en, input logic fn);
    logic ready;
    logic fire;
    logic [NC*DW-1:0] nd;
    bus.i_drive    = drv;
    bus.i_data     = dat;
    bus.i_chEn     = en;
    bus.i_freeNext = fn;
    ready = 1'b1;
    for (int k = 0; k < NC; k++)
      if (en[k] && q[k].size() == 0) ready = 1'b0;
    fire = (en != '0) && ready && (!m_full || fn);
    nd = '0;
    if (fire)
      for (int k = 0; k < NC; k++)
        if (en[k]) nd[k*DW +: DW] = q[k].pop_front();
    for (int k = 0; k < NC; k++)
      if (drv[k]) begin
        if (q[k].size() < D) q[k].push_back(dat[k*DW +: DW]);
        else m_ovf[k] = 1'b1;
      end
    m_dn   = fire;
    m_free = fire ? en : '0;
    if (fire) begin
      m_full = 1'b1;
      m_data = nd;
    end else if (fn) begin
      m_full = 1'b0;
    end
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic idle(input int n, input logic [NC-1:0] en);
    for (int i = 0; i < n; i++) cycle('0, '0, en, 1'b0);
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    bus.i_drive = '0;
    bus.i_data = '0;
    bus.i_chEn = '0;
    bus.i_freeNext = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rstn = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_chk  = 0;
    n_fail = 0;
    do_reset();
    check_all();
    check_eq("rst_busy", bus.o_busy, 1'b0);

    // Simultaneous arrival on all channels.
    idle(4, 3'b111);
    cycle(3'b111, 12'h321, 3'b111, 1'b0);
    idle(1, 3'b111);
    check_eq("dir_dn",   bus.o_driveNext, 1'b1);
    check_eq("dir_data", bus.o_data, 12'h321);
    check_eq("dir_free", bus.o_free, 3'b111);
    idle(2, 3'b111);
    check_eq("dir_hold", bus.o_busy, 1'b1);
    cycle('0, '0, 3'b111, 1'b1);
    check_eq("dir_rel", bus.o_busy, 1'b0);

    // Mask: ch1 disabled and left empty.
    cycle(3'b101, 12'hC0A, 3'b101, 1'b0);
    idle(1, 3'b101);
    check_eq("mask_data", bus.o_data, 12'hC0A);
    check_eq("mask_free", bus.o_free, 3'b101);
    cycle('0, '0, 3'b101, 1'b1);

    // Staggered arrival.
    cycle(3'b001, 12'h005, 3'b111, 1'b0);
    idle(2, 3'b111);
    cycle(3'b010, 12'h060, 3'b111, 1'b0);
    idle(3, 3'b111);
    cycle(3'b100, 12'h700, 3'b111, 1'b0);
    idle(3, 3'b111);
    cycle('0, '0, 3'b111, 1'b1);

    // Back-pressure and overflow on ch1.
    cycle(3'b111, 12'h111, 3'b111, 1'b0);
    cycle(3'b111, 12'h222, 3'b111, 1'b0);
    cycle(3'b111, 12'h333, 3'b111, 1'b0);
    cycle(3'b010, 12'h040, 3'b111, 1'b0);
    idle(3, 3'b111);
    check_eq("bp_ovf1", bus.o_ovf[1], 1'b1);
    for (int i = 0; i < 4; i++) cycle('0, '0, 3'b111, 1'b1);

    // Random traffic, full enable then random masks.
    for (int i = 0; i < 400; i++)
      cycle(NC'($urandom), (NC*DW)'($urandom), 3'b111, 1'($urandom_range(0, 1)));
    for (int i = 0; i < 400; i++)
      cycle(NC'($urandom), (NC*DW)'($urandom), NC'($urandom), 1'($urandom_range(0, 1)));

    // Throughput: fresh reset, push every cycle, free right after each merge.
    do_reset();
    for (int i = 0; i < 100; i++)
      cycle(3'b111, (NC*DW)'($urandom), 3'b111, m_dn);

    // Reset mid-operation with a buffered token and a full output slot.
    do_reset();
    cycle(3'b111, 12'h456, 3'b111, 1'b0);
    cycle(3'b111, 12'h789, 3'b111, 1'b0);
    idle(1, 3'b111);
    #2 rstn = 1'b0;
    #1;
    model_reset();
    check_all();
    check_eq("rst_async_busy", bus.o_busy, 1'b0);
    bus.i_drive = '0;
    bus.i_freeNext = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rstn = 1'b1;
    @(posedge clk);
    #1;
    check_all();
    idle(5, 3'b111);
    cycle(3'b111, 12'hABC, 3'b111, 1'b0);
    idle(2, 3'b111);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
